// File: rtl/mdr_mem_reader_if.sv
// Memory read handshake between the MDR load path (master) and memory (slave).
interface mdr_mem_reader_if #(
   parameter int DATA_W = 16
);
   logic              mem_rd_req;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_data;

   modport master (
      output mem_rd_req,
      input  mem_ack,
      input  mem_data
   );

   modport slave (
      input  mem_rd_req,
      output mem_ack,
      output mem_data
   );
endinterface

// File: rtl/mdr_mem_reader.sv
// MDR memory-side load path: request/acknowledge read into the MDR, drives it to the bus.
// Optional read timeout with sticky error flag is enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_reader #(
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_rd_start,
   mdr_mem_reader_if.master      mem,
   input  logic                  i_mdr_to_bus_en,
   output logic [DATA_W-1:0]     o_bus_data,
   output logic                  o_bus_oe,
   output logic                  o_busy,
   output logic                  o_data_valid,
   output logic                  o_rd_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_VALID = 2'd2;

   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_mdr;
   logic              w_in_req;
   logic              w_start_ok;

   assign w_in_req   = (r_state == S_REQ);
   assign w_start_ok = i_rd_start && (r_state != S_REQ);

`ifdef MDR_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_cnt;
   logic       r_rd_err;
   logic       w_expire;

   // An ack in the expiry cycle wins, so expiry requires mem_ack low.
   assign w_expire = w_in_req && !mem.mem_ack && (r_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_rd_err <= 1'b0;
      end else if (w_start_ok) begin
         r_cnt    <= '0;
         r_rd_err <= 1'b0;
      end else if (w_expire) begin
         r_rd_err <= 1'b1;
      end else if (w_in_req && !mem.mem_ack) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_rd_err = r_rd_err;
`else
   logic w_expire;

   assign w_expire = 1'b0;
   assign o_rd_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mdr   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_rd_start) r_state <= S_REQ;
            end
            S_REQ: begin
               if (mem.mem_ack) begin
                  r_state <= S_VALID;
                  r_mdr   <= mem.mem_data;
               end else if (w_expire) begin
                  r_state <= S_IDLE;
               end
            end
            S_VALID: begin
               if (i_rd_start) r_state <= S_REQ;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Stale drives are the control unit's responsibility; bus_oe is a straight pass-through.
   assign mem.mem_rd_req = w_in_req;
   assign o_busy         = w_in_req;
   assign o_data_valid   = (r_state == S_VALID);
   assign o_bus_oe       = i_mdr_to_bus_en;
   assign o_bus_data     = r_mdr;

endmodule

// File: tb/tb_mdr_mem_reader.sv
// Self-checking bench for mdr_mem_reader; captured words are checked against a scoreboard queue.
module tb_mdr_mem_reader;

   localparam int DATA_W = 16;
`ifdef MDR_TIMEOUT_EN
   localparam int TOUT = 4;
`else
   localparam int TOUT = 16;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              rdStart;
   logic              busEn;
   logic [DATA_W-1:0] busData;
   logic              busOe;
   logic              busy;
   logic              dataValid;
   logic              rdErr;

   int testCount = 0;
   int failCount = 0;
   logic [DATA_W-1:0] expQ[$];
   logic prevValid = 1'b0;

   mdr_mem_reader_if #(.DATA_W(DATA_W)) memIf ();

   mdr_mem_reader #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TOUT)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_rd_start      (rdStart),
      .mem             (memIf),
      .i_mdr_to_bus_en (busEn),
      .o_bus_data      (busData),
      .o_bus_oe        (busOe),
      .o_busy          (busy),
      .o_data_valid    (dataValid),
      .o_rd_err        (rdErr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic start, input logic ack, input logic [DATA_W-1:0] data);
      rdStart       = start;
      memIf.mem_ack  = ack;
      memIf.mem_data = data;
      if (ack && busy) expQ.push_back(data);
   endtask

   // Every rising data_valid must present the oldest outstanding expected word.
   always @(negedge clk) begin
      if (dataValid && !prevValid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedCapture", 32'(busData), 32'hDEAD_0000);
         end else begin
            checkOutput("sbCapture", 32'(busData), 32'(expQ.pop_front()));
         end
      end
      prevValid <= dataValid;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int reqCycles;

      rst = 1'b1;
      busEn = 1'b0;
      applyStimulus(1'b0, 1'b0, '0);
      step();
      step();
      rst = 1'b0;
      checkOutput("rstBusData", 32'(busData), 32'h0);
      checkOutput("rstReq", 32'(memIf.mem_rd_req), 32'h0);
      checkOutput("rstValid", 32'(dataValid), 32'h0);
      checkOutput("rstErr", 32'(rdErr), 32'h0);
      checkOutput("rstBusy", 32'(busy), 32'h0);

      // ack while idle is ignored
      applyStimulus(1'b0, 1'b1, 16'h1111);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("idleAckBus", 32'(busData), 32'h0);
      checkOutput("idleAckValid", 32'(dataValid), 32'h0);

      // zero-wait read
      applyStimulus(1'b1, 1'b0, '0);
      step();
      checkOutput("zwReq", 32'(memIf.mem_rd_req), 32'h1);
      checkOutput("zwBusy", 32'(busy), 32'h1);
      busEn = 1'b1;
      applyStimulus(1'b0, 1'b1, 16'hBEEF);
      #1;
      checkOutput("zwOeSameCycle", 32'(busOe), 32'h1);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("zwValid", 32'(dataValid), 32'h1);
      checkOutput("zwBus", 32'(busData), 32'hBEEF);
      checkOutput("zwReqDrop", 32'(memIf.mem_rd_req), 32'h0);
      checkOutput("zwBusyDrop", 32'(busy), 32'h0);
      busEn = 1'b0;
      #1;
      checkOutput("oeFollowsEn", 32'(busOe), 32'h0);

      // wait-state read with an ignored second start
      applyStimulus(1'b1, 1'b0, '0);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("wsValidCleared", 32'(dataValid), 32'h0);
      checkOutput("wsOldWordHeld", 32'(busData), 32'hBEEF);
      reqCycles = 0;
      for (int i = 0; i < 5; i++) begin
         if (memIf.mem_rd_req) reqCycles++;
         rdStart = (i == 2);
         step();
      end
      rdStart = 1'b0;
      checkOutput("wsReqHeld", 32'(reqCycles), 32'd5);
      busEn = 1'b1;
      #1;
      checkOutput("oeInReq", 32'(busOe), 32'h1);
      busEn = 1'b0;
      applyStimulus(1'b0, 1'b1, 16'h1234);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("wsBus", 32'(busData), 32'h1234);
      step();
      step();
      checkOutput("wsNoSecondReq", 32'(memIf.mem_rd_req), 32'h0);
      checkOutput("wsStillValid", 32'(dataValid), 32'h1);

      // back-to-back reads
      applyStimulus(1'b1, 1'b0, '0);
      step();
      applyStimulus(1'b0, 1'b1, 16'hAAAA);
      step();
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("b2bFirst", 32'(busData), 32'hAAAA);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("b2bValidLow", 32'(dataValid), 32'h0);
      checkOutput("b2bOldWord", 32'(busData), 32'hAAAA);
      step();
      checkOutput("b2bOldWord2", 32'(busData), 32'hAAAA);
      applyStimulus(1'b0, 1'b1, 16'h5555);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("b2bSecond", 32'(busData), 32'h5555);
      checkOutput("b2bValid", 32'(dataValid), 32'h1);

      // reset mid-read beats a same-cycle ack
      applyStimulus(1'b1, 1'b0, '0);
      step();
      rdStart = 1'b0;
      memIf.mem_ack = 1'b1;
      memIf.mem_data = 16'hFFFF;
      rst = 1'b1;
      step();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("rmrBus", 32'(busData), 32'h0);
      checkOutput("rmrValid", 32'(dataValid), 32'h0);
      checkOutput("rmrReq", 32'(memIf.mem_rd_req), 32'h0);
      checkOutput("rmrBusy", 32'(busy), 32'h0);

      // ack while valid is ignored
      applyStimulus(1'b1, 1'b0, '0);
      step();
      applyStimulus(1'b0, 1'b1, 16'hCAFE);
      step();
      applyStimulus(1'b0, 1'b1, 16'h0BAD);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("validAckIgnored", 32'(busData), 32'hCAFE);

`ifdef MDR_TIMEOUT_EN
      applyStimulus(1'b1, 1'b0, '0);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      reqCycles = 0;
      while (memIf.mem_rd_req && reqCycles < 20) begin
         reqCycles++;
         step();
      end
      checkOutput("toReqCycles", 32'(reqCycles), 32'(TOUT));
      checkOutput("toErr", 32'(rdErr), 32'h1);
      checkOutput("toBusy", 32'(busy), 32'h0);
      checkOutput("toValid", 32'(dataValid), 32'h0);
      checkOutput("toMdrKept", 32'(busData), 32'hCAFE);
      step();
      checkOutput("toErrSticky", 32'(rdErr), 32'h1);
      applyStimulus(1'b1, 1'b0, '0);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("toErrCleared", 32'(rdErr), 32'h0);
      for (int i = 0; i < TOUT - 1; i++) step();
      checkOutput("toLastCycleReq", 32'(memIf.mem_rd_req), 32'h1);
      applyStimulus(1'b0, 1'b1, 16'h4444);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("toAckWinsBus", 32'(busData), 32'h4444);
      checkOutput("toAckWinsValid", 32'(dataValid), 32'h1);
      checkOutput("toAckWinsErr", 32'(rdErr), 32'h0);
`else
      applyStimulus(1'b1, 1'b0, '0);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      for (int i = 0; i < 40; i++) step();
      checkOutput("noToReqHeld", 32'(memIf.mem_rd_req), 32'h1);
      checkOutput("noToErr", 32'(rdErr), 32'h0);
      applyStimulus(1'b0, 1'b1, 16'h7777);
      step();
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("noToBus", 32'(busData), 32'h7777);
      checkOutput("noToValid", 32'(dataValid), 32'h1);
`endif

      step();
      step();
      checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/mdr_mem_reader.md
# mdr_mem_reader

Memory-side load path of the Memory Data Register. It is the read counterpart to the bus-to-MDR latch. On a start pulse it runs a request/acknowledge read handshake with memory and captures the returned word into the MDR. When enabled, it presents the held word to the shared 16-bit internal bus through an output-enable for the external tri-state driver. It sits between the memory interface and the datapath bus, under control-unit sequencing.

## Interface
Parameters:
- DATA_W, 16, width of MDR, memory data and bus data
- TIMEOUT_CYCLES, 16, maximum cycles mem_rd_req stays high without mem_ack (legal range 1..255; used only with MDR_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset rst, synchronous, active-high
- rd_start  in  1  one-cycle pulse, begin memory read
- mem_rd_req  out  1  read request to memory, held until acknowledged
- mem_ack  in  1  memory acknowledge; mem_data valid in same cycle
- mem_data  in  DATA_W  read data from memory
- mdr_to_bus_en  in  1  control-unit request to drive MDR onto bus
- bus_data  out  DATA_W  current MDR contents (always driven)
- bus_oe  out  1  tri-state enable for bus_data
- busy  out  1  read in progress (state REQ)
- data_valid  out  1  MDR holds a word from a completed read
- rd_err  out  1  last read timed out (sticky until next accepted rd_start)

## Operation
- States: IDLE, REQ, VALID. After reset: IDLE.
- Reset values: mdr=0 (so bus_data=0), mem_rd_req=0, busy=0, data_valid=0, rd_err=0, timeout counter=0.
- Transitions from IDLE:
  - IDLE + rd_start -> REQ. On entry: mem_rd_req=1, busy=1, counter=0, rd_err=0.
- Transitions from REQ:
  - REQ + mem_ack -> VALID. On this edge: mdr <= mem_data, data_valid=1, mem_rd_req=0, busy=0.
  - REQ, no mem_ack -> counter increments.
  - Timeout is covered under Configuration.
- Transitions from VALID:
  - VALID + rd_start -> REQ. data_valid=0; mdr keeps the old word until the new capture.
- Inputs that are ignored:
  - rd_start while in REQ.
  - mem_ack while in IDLE or VALID.
- Bus drive:
  - bus_oe = mdr_to_bus_en, combinational, in every state including REQ.
  - bus_data = mdr, combinational.
  - The control unit gates mdr_to_bus_en on data_valid. The block does not block stale drives.
- mdr changes only on a REQ+mem_ack edge or on rst. Width is exactly DATA_W, no extension or truncation.

## Timing
- rd_start sampled high at edge N -> mem_rd_req=1 after N.
- mem_ack sampled high at edge M (M>N) -> mdr, data_valid=1 and mem_rd_req=0 after M.
- Minimum latency: 2 cycles from rd_start to data_valid.
- Handshake:
  - mem_rd_req never drops before mem_ack, except on timeout or rst.
  - Memory must hold mem_data stable in every cycle mem_ack is high.
- bus_oe tracks mdr_to_bus_en in the same cycle, with zero latency.
- rst mid-read (REQ): at the next edge the state is IDLE, mem_rd_req=0, mdr=0. A mem_ack in that same cycle is discarded.
- rst has priority over all inputs.

## Configuration
- Macro: MDR_TIMEOUT_EN.
- Defined:
  - In REQ without ack, the counter increments every cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 with mem_ack low, the next edge gives IDLE, mem_rd_req=0, busy=0, rd_err=1, with mdr and data_valid unchanged (data_valid=0).
  - mem_rd_req is therefore high for exactly TIMEOUT_CYCLES cycles.
  - A mem_ack in the expiry cycle wins: normal capture, rd_err=0.
- Undefined:
  - No counter; REQ waits indefinitely.
  - rd_err is tied to 0.

## Test plan
- Reset then idle: assert rst 2 cycles -> bus_data=0x0000, mem_rd_req=0, data_valid=0, rd_err=0.
- Zero-wait read: rd_start at cycle 0, mem_ack with mem_data=0xBEEF at cycle 1 -> after edge 1, data_valid=1 and bus_data=0xBEEF. With mdr_to_bus_en=1, bus_oe=1 in the same cycle.
- Wait-state read: ack delayed 5 cycles, mem_data=0x1234 -> mem_rd_req held 5 cycles, then captured. A second rd_start during REQ is ignored; exactly one capture occurs.
- Back-to-back reads: read 0xAAAA, then rd_start in VALID, ack 0x5555 after 2 cycles -> bus_data=0xAAAA until the capture edge, data_valid=0 meanwhile, then 0x5555.
- Reset mid-read: rd_start, then rst in the same cycle as mem_ack=1 with 0xFFFF -> mdr=0, IDLE, data_valid=0.
- MDR_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack:
  - mem_rd_req high exactly 4 cycles, then rd_err=1 and busy=0.
  - Next rd_start clears rd_err.
  - Rerun with ack in the 4th cycle -> capture, rd_err=0.
